intctl: RTL and testbench

Interrupt sequencer for the register file. It samples the interrupt request lines at instruction boundaries and drives `ienabled`, `istatus` and `intRA` into the register file, so the alternate DX/DY pair latches the return address and then freezes. It also issues the fetch redirect to the handler vector, and on return-from-interrupt it switches the register file back to the main DX/DY pair.

---
 rtl/intctl_pkg.sv | 21 ++
 rtl/intctl_prienc.sv | 28 ++
 rtl/intctl.sv | 129 ++++++++++++
 tb/tb_intctl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/intctl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : intctl_pkg                                                  |
// | Brief  : Shared types and default constants for the interrupt        |
// |          sequencer.                                                  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package intctl_pkg;

    // Sequencer states; explicit width keeps encodings stable across tools
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ENTER  = 2'd1,
        ACTIVE = 2'd2
    } intctl_state_t;

    localparam logic [15:0] INTCTL_VECBASE_DEFAULT = 16'hFF00;
    localparam int unsigned INTCTL_VSTRIDE_DEFAULT = 16;

endpackage
`default_nettype wire

// File: rtl/intctl_prienc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : prienc                                                      |
// | Brief  : Lowest-index-wins priority encoder, purely combinational.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module prienc #(
    parameter int W  = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] index
);

    // Scan from the top down so the lowest set bit is the last writer
    always_comb begin
        valid = |req;
        index = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (req[i]) begin
                index = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/intctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : intctl                                                      |
// | Brief  : Interrupt sequencer. Samples requests at instruction        |
// |          boundaries, captures the return address, redirects fetch    |
// |          to the handler vector and switches the DX/DY pair.          |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module intctl
    import intctl_pkg::*;
#(
    parameter int          IRQW    = 4,
    parameter logic [15:0] VECBASE = INTCTL_VECBASE_DEFAULT,
    parameter int unsigned VSTRIDE = INTCTL_VSTRIDE_DEFAULT,
    parameter int          CW      = (IRQW > 1) ? $clog2(IRQW) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IRQW-1:0] irq,
    input  logic            boundary,
    input  logic [15:0]     pc_next,
    input  logic            ei,
    input  logic            di,
    input  logic            rti,
    output logic            ienabled,
    output logic            istatus,
    output logic [15:0]     intRA,
    output logic            take,
    output logic            hold,
    output logic [15:0]     vector,
    output logic [CW-1:0]   cause
);

    localparam logic [15:0] c_STRIDE16 = 16'(VSTRIDE);

    intctl_state_t  state_q;
    logic           ienabled_q;
    logic           ienabled_d;
    logic           istatus_q;
    logic [15:0]    intra_q;
    logic [CW-1:0]  cause_q;
    logic           take_q;
    logic           hold_q;

    logic           w_req_valid;
    logic [CW-1:0]  w_req_index;
    logic           w_enter;

    prienc #(
        .W  (IRQW),
        .IW (CW)
    ) u_prienc (
        .req   (irq),
        .valid (w_req_valid),
        .index (w_req_index)
    );

    // Enable update is state-independent; disable wins over enable
    always_comb begin
        ienabled_d = ienabled_q;
        if (boundary && di) begin
            ienabled_d = 1'b0;
        end else if (boundary && ei) begin
            ienabled_d = 1'b1;
        end
    end

    // Entry uses the registered enable, so a retiring ei only takes effect
    // at the following boundary; a retiring di blocks entry immediately
    assign w_enter = boundary && ienabled_q && w_req_valid && !di;

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ienabled_q <= 1'b0;
            istatus_q  <= 1'b0;
            intra_q    <= 16'h0000;
            cause_q    <= '0;
            take_q     <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            ienabled_q <= ienabled_d;
            take_q     <= 1'b0;
            hold_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    istatus_q <= 1'b0;
                    if (w_enter) begin
                        state_q <= ENTER;
                        intra_q <= pc_next;
                        cause_q <= w_req_index;
                        take_q  <= 1'b1;
                        hold_q  <= 1'b1;
                    end
                end
                // Register file copies intRA into the alternate pair this
                // cycle; raising istatus on the way out freezes that copy
                ENTER: begin
                    state_q   <= ACTIVE;
                    istatus_q <= 1'b1;
                end
                // No nesting: requests are not looked at while a handler runs
                ACTIVE: begin
                    if (boundary && rti) begin
                        state_q   <= IDLE;
                        istatus_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    istatus_q <= 1'b0;
                end
            endcase
        end
    end

    assign ienabled = ienabled_q;
    assign istatus  = istatus_q;
    assign intRA    = intra_q;
    assign cause    = cause_q;
    assign take     = take_q;
    assign hold     = hold_q;

    // Handler address wraps modulo 2^16
    assign vector   = VECBASE + (16'(cause_q) * c_STRIDE16);

endmodule
`default_nettype wire

// File: tb/tb_intctl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_intctl                                                   |
// | Brief  : Self-checking bench for intctl: vector table fed through a  |
// |          scoreboard queue, plus a bounded multi-cycle entry check.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_intctl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq;
    logic        boundary;
    logic [15:0] pc_next;
    logic        ei;
    logic        di;
    logic        rti;

    logic        ienabled, istatus, take, hold;
    logic [15:0] intRA, vector;
    logic [1:0]  cause;

    logic        w_ienabled, w_istatus, w_take, w_hold;
    logic [15:0] w_intRA, w_vector;
    logic [1:0]  w_cause;

    int n_cmp;
    int n_err;

    intctl #(.IRQW(4), .VECBASE(16'hFF00), .VSTRIDE(16)) u_dut (
        .clk(clk), .rst(rst), .irq(irq), .boundary(boundary),
        .pc_next(pc_next), .ei(ei), .di(di), .rti(rti),
        .ienabled(ienabled), .istatus(istatus), .intRA(intRA),
        .take(take), .hold(hold), .vector(vector), .cause(cause)
    );

    // Same stimulus, wrapping vector base
    intctl #(.IRQW(4), .VECBASE(16'hFFF0), .VSTRIDE(16)) u_wrap (
        .clk(clk), .rst(rst), .irq(irq), .boundary(boundary),
        .pc_next(pc_next), .ei(ei), .di(di), .rti(rti),
        .ienabled(w_ienabled), .istatus(w_istatus), .intRA(w_intRA),
        .take(w_take), .hold(w_hold), .vector(w_vector), .cause(w_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, bnd, ei, di, rti;
        logic [3:0]  irq;
        logic [15:0] pc;
        logic        take, hold, ist, ien;
        logic [15:0] ra;
        logic [1:0]  cause;
        logic [15:0] vec, wvec;
    } vec_t;

    vec_t tbl[22];
    vec_t sb[$];

    function automatic vec_t mk(logic r, logic b, logic e, logic d, logic t,
                                logic [3:0] q, logic [15:0] p,
                                logic tk, logic h, logic s, logic en,
                                logic [15:0] ra, logic [1:0] c,
                                logic [15:0] v, logic [15:0] wv);
        vec_t x;
        x.rst = r; x.bnd = b; x.ei = e; x.di = d; x.rti = t;
        x.irq = q; x.pc = p;
        x.take = tk; x.hold = h; x.ist = s; x.ien = en;
        x.ra = ra; x.cause = c; x.vec = v; x.wvec = wv;
        return x;
    endfunction

    task automatic chk(input string nm, input int row, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %h, expected %h", nm, row, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; boundary = v.bnd; ei = v.ei; di = v.di; rti = v.rti;
        irq = v.irq; pc_next = v.pc;
    endtask

    // Drive one vector, queue its expectation, then compare after the edge
    task automatic apply(input int row);
        vec_t e;
        drive(tbl[row]);
        sb.push_back(tbl[row]);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("take",     row, 16'(take),     16'(e.take));
        chk("hold",     row, 16'(hold),     16'(e.hold));
        chk("istatus",  row, 16'(istatus),  16'(e.ist));
        chk("ienabled", row, 16'(ienabled), 16'(e.ien));
        chk("intRA",    row, intRA,         e.ra);
        chk("cause",    row, 16'(cause),    16'(e.cause));
        chk("vector",   row, vector,        e.vec);
        chk("wrap_vec", row, w_vector,      e.wvec);
    endtask

    initial begin
        bit got;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; boundary = 1'b0; ei = 1'b0; di = 1'b0; rti = 1'b0;
        irq = 4'h0; pc_next = 16'h0000;

        //            rst bnd ei di rti irq      pc        tk h  st en ra       c  vec       wvec
        tbl[0]  = mk(1, 0, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'hFF00, 16'hFFF0);
        tbl[1]  = mk(0, 1, 1, 0, 0, 4'b0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 16'hFF00, 16'hFFF0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 4'b0100, 16'h1234, 1, 1, 0, 1, 16'h1234, 2, 16'hFF20, 16'h0010);
        tbl[3]  = mk(0, 1, 0, 0, 1, 4'b0000, 16'h0000, 0, 0, 1, 1, 16'h1234, 2, 16'hFF20, 16'h0010);
        tbl[4]  = mk(0, 1, 0, 0, 0, 4'b0001, 16'h0000, 0, 0, 1, 1, 16'h1234, 2, 16'hFF20, 16'h0010);
        tbl[5]  = mk(0, 1, 0, 0, 1, 4'b0001, 16'h0000, 0, 0, 0, 1, 16'h1234, 2, 16'hFF20, 16'h0010);
        tbl[6]  = mk(0, 1, 0, 0, 0, 4'b0001, 16'h2000, 1, 1, 0, 1, 16'h2000, 0, 16'hFF00, 16'hFFF0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 1, 1, 16'h2000, 0, 16'hFF00, 16'hFFF0);
        tbl[8]  = mk(0, 1, 0, 0, 1, 4'b0000, 16'h0000, 0, 0, 0, 1, 16'h2000, 0, 16'hFF00, 16'hFFF0);
        tbl[9]  = mk(0, 1, 0, 0, 0, 4'b1010, 16'h3000, 1, 1, 0, 1, 16'h3000, 1, 16'hFF10, 16'h0000);
        tbl[10] = mk(0, 0, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 1, 1, 16'h3000, 1, 16'hFF10, 16'h0000);
        tbl[11] = mk(0, 1, 0, 0, 1, 4'b0000, 16'h0000, 0, 0, 0, 1, 16'h3000, 1, 16'hFF10, 16'h0000);
        tbl[12] = mk(0, 1, 1, 1, 0, 4'b0000, 16'h0000, 0, 0, 0, 0, 16'h3000, 1, 16'hFF10, 16'h0000);
        tbl[13] = mk(0, 1, 1, 0, 0, 4'b0100, 16'h4000, 0, 0, 0, 1, 16'h3000, 1, 16'hFF10, 16'h0000);
        tbl[14] = mk(0, 1, 0, 0, 0, 4'b0100, 16'h4004, 1, 1, 0, 1, 16'h4004, 2, 16'hFF20, 16'h0010);
        tbl[15] = mk(0, 0, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 1, 1, 16'h4004, 2, 16'hFF20, 16'h0010);
        tbl[16] = mk(0, 1, 0, 0, 1, 4'b0000, 16'h0000, 0, 0, 0, 1, 16'h4004, 2, 16'hFF20, 16'h0010);
        tbl[17] = mk(0, 1, 0, 0, 0, 4'b1000, 16'h5000, 1, 1, 0, 1, 16'h5000, 3, 16'hFF30, 16'h0020);
        tbl[18] = mk(1, 0, 0, 0, 0, 4'b0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'hFF00, 16'hFFF0);
        tbl[19] = mk(0, 1, 0, 0, 1, 4'b0001, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 16'hFF00, 16'hFFF0);
        tbl[20] = mk(0, 1, 1, 0, 0, 4'b0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 0, 16'hFF00, 16'hFFF0);
        tbl[21] = mk(0, 1, 0, 1, 0, 4'b0001, 16'h7000, 0, 0, 0, 0, 16'h0000, 0, 16'hFF00, 16'hFFF0);

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            apply(i);
        end

        // Enable, then hold a request with boundary high and wait for entry
        boundary = 1'b1; ei = 1'b1; di = 1'b0; rti = 1'b0; irq = 4'b0000;
        @(posedge clk);
        #1;
        ei = 1'b0; irq = 4'b0010; pc_next = 16'h6000;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (take) begin
                got = 1'b1;
                break;
            end
        end
        chk("entry_seen", 100, 16'(got), 16'd1);
        chk("seq_intRA",  100, intRA,    16'h6000);
        chk("seq_cause",  100, 16'(cause), 16'd1);
        chk("seq_vector", 100, vector,   16'hFF10);
        boundary = 1'b0; irq = 4'b0000;
        @(posedge clk);
        #1;
        chk("seq_take_pulse", 101, 16'(take),    16'd0);
        chk("seq_istatus",    101, 16'(istatus), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
